// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: the hazard, redirect,
// multi-cycle, fetch-wait and debug-halt decode, plus saturating perf counters.
module pipeline_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_W          = 16,
    parameter int DRAIN_CYCLES   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                      id_rs1_used_i,
    input  logic                      id_rs2_used_i,
    input  logic                      ex_MemRead_i,
    input  logic                      ex_RegWrite_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic                      ex_redirect_i,
    input  logic                      ex_mc_start_i,
    input  logic                      mc_done_i,
    input  logic                      imem_ready_i,
    input  logic                      halt_req_i,
    output logic                      pc_we_o,
    output logic                      if_id_we_o,
    output logic                      if_id_flush_o,
    output logic                      id_ex_we_o,
    output logic                      id_ex_flush_o,
    output logic                      ex_mem_bubble_o,
    output logic                      halted_o,
    output logic [2:0]                state_o,
    output logic [CNT_W-1:0]          stall_cnt_o,
    output logic [CNT_W-1:0]          flush_cnt_o
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        RUN     = 3'd1,
        MC_WAIT = 3'd2,
        DRAIN   = 3'd3,
        HALTED  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             redirect_taken;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign load_use = ex_MemRead_i && ex_RegWrite_i && (ex_rd_addr_i != '0) &&
                      ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

    always_comb begin
        pc_we_o         = 1'b0;
        if_id_we_o      = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_we_o      = 1'b0;
        id_ex_flush_o   = 1'b0;
        ex_mem_bubble_o = 1'b0;
        halted_o        = 1'b0;
        redirect_taken  = 1'b0;
        state_d         = state_q;
        drain_d         = drain_q;

        case (state_q)
            BOOT: begin
                if_id_flush_o   = 1'b1;
                id_ex_flush_o   = 1'b1;
                ex_mem_bubble_o = 1'b1;
                state_d         = RUN;
            end
            RUN: begin
                pc_we_o    = 1'b1;
                if_id_we_o = 1'b1;
                id_ex_we_o = 1'b1;
                if (ex_redirect_i) begin
                    if_id_flush_o  = 1'b1;
                    id_ex_flush_o  = 1'b1;
                    redirect_taken = 1'b1;
                end else if (ex_mc_start_i) begin
                    pc_we_o         = 1'b0;
                    if_id_we_o      = 1'b0;
                    id_ex_we_o      = 1'b0;
                    ex_mem_bubble_o = 1'b1;
                    state_d         = MC_WAIT;
                end else if (load_use) begin
                    pc_we_o       = 1'b0;
                    if_id_we_o    = 1'b0;
                    id_ex_flush_o = 1'b1;
                end else if (!imem_ready_i) begin
                    pc_we_o       = 1'b0;
                    if_id_flush_o = 1'b1;
                end else if (halt_req_i) begin
                    pc_we_o       = 1'b0;
                    if_id_flush_o = 1'b1;
                    drain_d       = DW'(DRAIN_CYCLES - 1);
                    state_d       = DRAIN;
                end
            end
            MC_WAIT: begin
                if (mc_done_i) begin
                    pc_we_o    = 1'b1;
                    if_id_we_o = 1'b1;
                    id_ex_we_o = 1'b1;
                    state_d    = RUN;
                end else begin
                    ex_mem_bubble_o = 1'b1;
                end
            end
            DRAIN: begin
                if_id_we_o    = 1'b1;
                if_id_flush_o = 1'b1;
                id_ex_we_o    = 1'b1;
                if (ex_redirect_i) begin
                    pc_we_o        = 1'b1;
                    id_ex_flush_o  = 1'b1;
                    redirect_taken = 1'b1;
                end else if (load_use) begin
                    // Hold the dependent instruction in IF/ID rather than dropping it.
                    if_id_we_o    = 1'b0;
                    if_id_flush_o = 1'b0;
                    id_ex_flush_o = 1'b1;
                end
                if (drain_q == '0) begin
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            HALTED: begin
                halted_o        = 1'b1;
                id_ex_flush_o   = 1'b1;
                ex_mem_bubble_o = 1'b1;
                if (!halt_req_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                if_id_flush_o   = 1'b1;
                id_ex_flush_o   = 1'b1;
                ex_mem_bubble_o = 1'b1;
                state_d         = BOOT;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if ((state_q == RUN || state_q == MC_WAIT || state_q == DRAIN) && !pc_we_o) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        flush_cnt_d = redirect_taken ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random traffic,
// each cycle's expected controls queued by a reference model and checked by a monitor.
module tb_pipeline_ctrl;

    localparam int AW   = 5;
    localparam int CW   = 6;
    localparam int DC   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
    logic          id_rs1_used_i, id_rs2_used_i;
    logic          ex_MemRead_i, ex_RegWrite_i, ex_redirect_i, ex_mc_start_i;
    logic          mc_done_i, imem_ready_i, halt_req_i;
    logic          pc_we_o, if_id_we_o, if_id_flush_o, id_ex_we_o, id_ex_flush_o;
    logic          ex_mem_bubble_o, halted_o;
    logic [2:0]    state_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    pipeline_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_W(CW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_MemRead_i(ex_MemRead_i), .ex_RegWrite_i(ex_RegWrite_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_redirect_i(ex_redirect_i),
        .ex_mc_start_i(ex_mc_start_i), .mc_done_i(mc_done_i),
        .imem_ready_i(imem_ready_i), .halt_req_i(halt_req_i),
        .pc_we_o(pc_we_o), .if_id_we_o(if_id_we_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_we_o(id_ex_we_o), .id_ex_flush_o(id_ex_flush_o),
        .ex_mem_bubble_o(ex_mem_bubble_o), .halted_o(halted_o), .state_o(state_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst_n;
        bit [AW-1:0] rs1, rs2, rd;
        bit          u1, u2, mr, rw, redir, mcs, mcd, imr, halt;
    } in_t;

    typedef struct {
        bit [5:0] ctrl;   // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, bubble}
        bit       halted;
        int       state, stall, flush;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: operating mode 0..4, cycles left in drain, event counts.
    int m_mode = 0, m_drain = 0, m_stall = 0, m_flush = 0;
    bit cur_halt = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    function automatic int bump(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic model_step(input in_t i, output exp_t e);
        bit lu;
        int nxt;
        bit redirected;
        if (!i.rst_n) begin
            m_mode = 0; m_stall = 0; m_flush = 0;
        end
        lu = i.mr && i.rw && (i.rd != 0) &&
             ((i.u1 && i.rs1 == i.rd) || (i.u2 && i.rs2 == i.rd));
        e.state  = m_mode;
        e.stall  = m_stall;
        e.flush  = m_flush;
        e.halted = (m_mode == 4);
        nxt = m_mode;
        redirected = 0;
        case (m_mode)
            0: begin e.ctrl = 6'b001011; nxt = 1; end
            1: begin
                if (i.redir)      begin e.ctrl = 6'b111110; redirected = 1; end
                else if (i.mcs)   begin e.ctrl = 6'b000001; nxt = 2; end
                else if (lu)      e.ctrl = 6'b000110;
                else if (!i.imr)  e.ctrl = 6'b011100;
                else if (i.halt)  begin e.ctrl = 6'b011100; nxt = 3; m_drain = DC - 1; end
                else              e.ctrl = 6'b110100;
            end
            2: begin
                if (i.mcd) begin e.ctrl = 6'b110100; nxt = 1; end
                else       e.ctrl = 6'b000001;
            end
            3: begin
                if (i.redir)  begin e.ctrl = 6'b111110; redirected = 1; end
                else if (lu)  e.ctrl = 6'b000110;
                else          e.ctrl = 6'b011100;
                if (m_drain == 0) nxt = 4;
                else              m_drain--;
            end
            default: begin e.ctrl = 6'b000011; if (!i.halt) nxt = 1; end
        endcase
        if (!i.rst_n) begin
            m_mode = 0;
        end else begin
            if (m_mode >= 1 && m_mode <= 3 && !e.ctrl[5]) m_stall = bump(m_stall);
            if (redirected) m_flush = bump(m_flush);
            m_mode = nxt;
        end
    endtask

    task automatic apply(input in_t i);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = i.rst_n;
        id_rs1_addr_i = i.rs1; id_rs2_addr_i = i.rs2; ex_rd_addr_i = i.rd;
        id_rs1_used_i = i.u1;  id_rs2_used_i = i.u2;
        ex_MemRead_i = i.mr;   ex_RegWrite_i = i.rw;
        ex_redirect_i = i.redir; ex_mc_start_i = i.mcs; mc_done_i = i.mcd;
        imem_ready_i = i.imr;  halt_req_i = i.halt;
        model_step(i, e);
        exp_q.push_back(e);
        #2;
    endtask

    function automatic in_t idle();
        in_t i;
        i = '{default: 0};
        i.rst_n = 1;
        i.imr   = 1;
        return i;
    endfunction

    function automatic in_t rand_in();
        in_t i;
        i = idle();
        i.rs1 = AW'($urandom_range(0, 3));
        i.rs2 = AW'($urandom_range(0, 3));
        i.rd  = AW'($urandom_range(0, 3));
        i.u1  = 1'($urandom);
        i.u2  = 1'($urandom);
        i.mr  = ($urandom_range(0, 2) == 0);
        i.rw  = ($urandom_range(0, 3) != 0);
        i.redir = ($urandom_range(0, 7) == 0);
        i.mcs = ($urandom_range(0, 9) == 0);
        i.mcd = (m_mode == 2) && ($urandom_range(0, 3) == 0);
        i.imr = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 19) == 0) cur_halt = !cur_halt;
        i.halt = cur_halt;
        return i;
    endfunction

    // Monitor: every cycle presents a control word; compare it with the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_we",       int'(pc_we_o),         int'(e.ctrl[5]));
                chk("if_id_we",    int'(if_id_we_o),      int'(e.ctrl[4]));
                chk("if_id_flush", int'(if_id_flush_o),   int'(e.ctrl[3]));
                chk("id_ex_we",    int'(id_ex_we_o),      int'(e.ctrl[2]));
                chk("id_ex_flush", int'(id_ex_flush_o),   int'(e.ctrl[1]));
                chk("bubble",      int'(ex_mem_bubble_o), int'(e.ctrl[0]));
                chk("halted",      int'(halted_o),        int'(e.halted));
                chk("state",       int'(state_o),         e.state);
                chk("stall_cnt",   int'(stall_cnt_o),     e.stall);
                chk("flush_cnt",   int'(flush_cnt_o),     e.flush);
            end
        end
    end

    initial begin
        in_t i;
        rst_n = 1'b0;
        id_rs1_addr_i = '0; id_rs2_addr_i = '0; ex_rd_addr_i = '0;
        id_rs1_used_i = 0; id_rs2_used_i = 0; ex_MemRead_i = 0; ex_RegWrite_i = 0;
        ex_redirect_i = 0; ex_mc_start_i = 0; mc_done_i = 0;
        imem_ready_i = 1; halt_req_i = 0;

        // Reset and boot
        i = idle(); i.rst_n = 0;
        apply(i); apply(i);
        chk("rst_pc_we", int'(pc_we_o), 0);
        chk("rst_flush", int'(if_id_flush_o && id_ex_flush_o && ex_mem_bubble_o), 1);
        apply(idle());
        chk("boot_state", int'(state_o), 0);
        chk("boot_pc_we", int'(pc_we_o), 0);
        apply(idle());
        chk("run_state", int'(state_o), 1);
        chk("run_we", int'(pc_we_o && if_id_we_o && id_ex_we_o), 1);
        chk("run_cnts", int'(stall_cnt_o) + int'(flush_cnt_o), 0);

        // Load-use on rs2, then the same pattern against x0
        i = idle(); i.mr = 1; i.rw = 1; i.rd = 5; i.rs2 = 5; i.u2 = 1;
        apply(i);
        chk("lu_pc_we", int'(pc_we_o), 0);
        chk("lu_if_id_we", int'(if_id_we_o), 0);
        chk("lu_id_ex_flush", int'(id_ex_flush_o), 1);
        apply(idle());
        chk("lu_stall_cnt", int'(stall_cnt_o), 1);
        chk("lu_one_cycle", int'(pc_we_o), 1);
        i.rd = 0; i.rs2 = 0;
        apply(i);
        chk("x0_no_stall", int'(pc_we_o), 1);

        // Redirect beats multi-cycle start and load-use
        i = idle(); i.redir = 1; i.mcs = 1; i.mr = 1; i.rw = 1; i.rd = 3; i.rs1 = 3; i.u1 = 1;
        apply(i);
        chk("redir_pc_we", int'(pc_we_o), 1);
        chk("redir_flushes", int'(if_id_flush_o && id_ex_flush_o), 1);
        apply(idle());
        chk("redir_state", int'(state_o), 1);
        chk("redir_flush_cnt", int'(flush_cnt_o), 1);

        // Multi-cycle op: entry plus six waiting cycles, released on done
        i = idle(); i.mcs = 1;
        apply(i);
        chk("mc_entry_bubble", int'(ex_mem_bubble_o), 1);
        for (int k = 0; k < 6; k++) begin
            apply(idle());
            chk("mc_wait_pc_we", int'(pc_we_o), 0);
        end
        i = idle(); i.mcd = 1;
        apply(i);
        chk("mc_done_release", int'(pc_we_o && !ex_mem_bubble_o), 1);
        apply(idle());
        chk("mc_back_run", int'(state_o), 1);
        chk("mc_stall_cnt", int'(stall_cnt_o), 8);

        // Debug halt: four drain cycles, halted, release
        i = idle(); i.halt = 1;
        apply(i);
        for (int k = 0; k < 4; k++) begin
            apply(i);
            chk("drain_state", int'(state_o), 3);
        end
        apply(i);
        chk("halted_state", int'(state_o), 4);
        chk("halted_o", int'(halted_o), 1);
        apply(idle());
        chk("halt_drop_same", int'(halted_o), 1);
        apply(idle());
        chk("resume_state", int'(state_o), 1);
        chk("resume_pc_we", int'(pc_we_o), 1);
        chk("halt_stall_cnt", int'(stall_cnt_o), 13);

        // Asynchronous reset in the middle of a multi-cycle wait
        i = idle(); i.mcs = 1;
        apply(i);
        apply(idle());
        i = idle(); i.rst_n = 0;
        apply(i);
        chk("async_rst_state", int'(state_o), 0);
        chk("async_rst_cnts", int'(stall_cnt_o) + int'(flush_cnt_o), 0);
        apply(idle());
        chk("post_rst_boot", int'(state_o), 0);
        apply(idle());
        chk("post_rst_run", int'(state_o), 1);

        // Random traffic; counters run into saturation along the way
        for (int n = 0; n < 3000; n++) apply(rand_in());
        chk("stall_saturated", int'(stall_cnt_o), MAXC);
        chk("flush_saturated", int'(flush_cnt_o), MAXC);

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
